arithmetic_logic_unit: RTL and testbench

- 32-bit registered ALU in the execution stage of the single-thread microprocessor.
- Selects its operands from the register file, the sign-extended immediate or the next PC.
- Performs one of 15 arithmetic, logic, compare or shift operations.
- Registers the result together with overflow and zero flags; one-cycle latency with pipeline freeze support.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 104 ++++++++++
 rtl/arithmetic_logic_unit.sv | 52 +++++
 tb/tb_arithmetic_logic_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and operation encodings for the execution-stage ALU.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_MUL  = 4'b0011,
    ALU_DIV  = 4'b0100,
    ALU_AND  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_NAND = 4'b0111,
    ALU_NOR  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SLT  = 4'b1010,
    ALU_SGT  = 4'b1011,
    ALU_SLL  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SLA  = 4'b1110,
    ALU_SRA  = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU operation and overflow logic; no state.
module alu_core
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  alu_op_e          op,
  input  logic             unsigned_operation,
  output logic [WIDTH-1:0] result,
  output logic             over_flow
);

  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       diff;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       divisor;
  logic [WIDTH-1:0]       quot;
  logic                   div_min_neg1;
  logic                   less;
  logic                   greater;
  logic [SHAMT_W-1:0]     sh;
  logic [WIDTH-1:0]       sla_res;

  always_comb begin
    sum  = {1'b0, op1} + {1'b0, op2};
    diff = op1 - op2;

    // Sign-extending before the multiply gives the exact signed product in 2*WIDTH bits.
    if (unsigned_operation)
      prod = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
    else
      prod = {{WIDTH{op1[WIDTH-1]}}, op1} * {{WIDTH{op2[WIDTH-1]}}, op2};

    // Substitute divisor keeps the divider free of X when op2 is zero.
    divisor      = (op2 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : op2;
    div_min_neg1 = !unsigned_operation && (op1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (op2 == {WIDTH{1'b1}});
    if (unsigned_operation)
      quot = op1 / divisor;
    else if (div_min_neg1)
      quot = op1;
    else
      quot = $signed(op1) / $signed(divisor);

    less    = unsigned_operation ? (op1 < op2) : ($signed(op1) < $signed(op2));
    greater = unsigned_operation ? (op1 > op2) : ($signed(op1) > $signed(op2));

    sh      = op2[SHAMT_W-1:0];
    sla_res = op1 << sh;

    result    = '0;
    over_flow = 1'b0;
    unique case (op)
      ALU_NOP: begin
        result    = '0;
        over_flow = 1'b0;
      end
      ALU_ADD: begin
        result    = sum[WIDTH-1:0];
        over_flow = unsigned_operation ? sum[WIDTH]
                  : ((op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]));
      end
      ALU_SUB: begin
        result    = diff;
        over_flow = unsigned_operation ? (op1 < op2)
                  : ((op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]));
      end
      ALU_MUL: begin
        result    = prod[WIDTH-1:0];
        over_flow = unsigned_operation ? (prod[2*WIDTH-1:WIDTH] != '0)
                  : (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
      end
      ALU_DIV: begin
        if (op2 == '0) begin
          result    = {WIDTH{1'b1}};
          over_flow = 1'b1;
        end else begin
          result    = quot;
          over_flow = div_min_neg1;
        end
      end
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_NAND: result = ~(op1 & op2);
      ALU_NOR:  result = ~(op1 | op2);
      ALU_XOR:  result = op1 ^ op2;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, less};
      ALU_SGT:  result = {{(WIDTH-1){1'b0}}, greater};
      ALU_SLL:  result = op1 << sh;
      ALU_SRL:  result = op1 >> sh;
      ALU_SLA: begin
        // Lossless iff shifting back arithmetically restores the original operand.
        result    = sla_res;
        over_flow = (WIDTH'($signed(sla_res) >>> sh) != op1);
      end
      ALU_SRA:  result = WIDTH'($signed(op1) >>> sh);
      default: begin
        result    = '0;
        over_flow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Execution-stage ALU: operand muxes, combinational core, and the
// freeze-able result/flag registers (one-cycle latency).
module arithmetic_logic_unit
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             freeze,
  input  logic             unsigned_operation,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [WIDTH-1:0] immx,
  input  logic [WIDTH-1:0] npc,
  input  logic             isImmediate,
  input  logic             notBUOp,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             overFlow,
  output logic             zero
);

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] core_result;
  logic             core_over_flow;

  assign op1 = notBUOp ? inp1 : npc;
  assign op2 = isImmediate ? immx : inp2;

  alu_core u_core (
    .op1                (op1),
    .op2                (op2),
    .op                 (alu_op_e'(ALUControl)),
    .unsigned_operation (unsigned_operation),
    .result             (core_result),
    .over_flow          (core_over_flow)
  );

  // Reset wins over freeze; the zero flag tracks the value being captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      ALUResult <= '0;
      overFlow  <= 1'b0;
      zero      <= 1'b0;
    end else if (!freeze) begin
      ALUResult <= core_result;
      overFlow  <= core_over_flow;
      zero      <= (core_result == '0);
    end
  end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed self-checking bench for arithmetic_logic_unit with hand-computed vectors.
module tb_arithmetic_logic_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        freeze;
  logic        unsigned_operation;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic [31:0] immx;
  logic [31:0] npc;
  logic        isImmediate;
  logic        notBUOp;
  logic [3:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        overFlow;
  logic        zero;

  int n_checks = 0;
  int n_passed = 0;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, MUL = 4'h3, DIV = 4'h4,
                         AND_ = 4'h5, OR_ = 4'h6, NAND_ = 4'h7, NOR_ = 4'h8, XOR_ = 4'h9,
                         SLT = 4'hA, SGT = 4'hB, SLL = 4'hC, SRL = 4'hD, SLA = 4'hE, SRA = 4'hF;

  arithmetic_logic_unit dut (
    .clock              (clock),
    .reset              (reset),
    .freeze             (freeze),
    .unsigned_operation (unsigned_operation),
    .inp1               (inp1),
    .inp2               (inp2),
    .immx               (immx),
    .npc                (npc),
    .isImmediate        (isImmediate),
    .notBUOp            (notBUOp),
    .ALUControl         (ALUControl),
    .ALUResult          (ALUResult),
    .overFlow           (overFlow),
    .zero               (zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_o,
                       input logic exp_z);
    n_checks++;
    assert (ALUResult === exp_r) n_passed++;
    else $error("FAIL %s result: got %h expected %h", tag, ALUResult, exp_r);
    n_checks++;
    assert (overFlow === exp_o) n_passed++;
    else $error("FAIL %s overFlow: got %b expected %b", tag, overFlow, exp_o);
    n_checks++;
    assert (zero === exp_z) n_passed++;
    else $error("FAIL %s zero: got %b expected %b", tag, zero, exp_z);
  endtask

  // Drive register operands, wait one capture edge, then sample 1 time unit later.
  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic uns, input logic [31:0] exp_r,
                      input logic exp_o, input logic exp_z);
    notBUOp            = 1'b1;
    isImmediate        = 1'b0;
    ALUControl         = op;
    inp1               = a;
    inp2               = b;
    unsigned_operation = uns;
    @(posedge clock);
    #1;
    check(tag, exp_r, exp_o, exp_z);
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; unsigned_operation = 1'b0;
    inp1 = 32'h0; inp2 = 32'h0; immx = 32'h0; npc = 32'h0;
    isImmediate = 1'b0; notBUOp = 1'b1; ALUControl = NOP;
    @(posedge clock); #1;
    check("reset", 32'h0, 1'b0, 1'b0);

    reset = 1'b0; freeze = 1'b1;
    step("freeze_after_reset", ADD, 32'd0, 32'd4, 1'b0, 32'h0, 1'b0, 1'b0);
    freeze = 1'b0;

    step("add_0_4",  ADD, 32'd0, 32'd4, 1'b0, 32'd4,        1'b0, 1'b0);
    step("sub_0_4",  SUB, 32'd0, 32'd4, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0);
    step("div_0_4",  DIV, 32'd0, 32'd4, 1'b0, 32'd0,        1'b0, 1'b1);
    step("sll_0_4",  SLL, 32'd0, 32'd4, 1'b0, 32'd0,        1'b0, 1'b1);
    step("slt_0_4",  SLT, 32'd0, 32'd4, 1'b0, 32'd1,        1'b0, 1'b0);

    step("mul_2_5",  MUL, 32'd2, 32'd5, 1'b0, 32'd10,       1'b0, 1'b0);
    step("sub_2_5",  SUB, 32'd2, 32'd5, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0);
    step("sgt_2_5",  SGT, 32'd2, 32'd5, 1'b0, 32'd0,        1'b0, 1'b1);
    step("sla_2_5",  SLA, 32'd2, 32'd5, 1'b0, 32'h40,       1'b0, 1'b0);
    step("div_5_0",  DIV, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);

    step("and_8_12",  AND_,  32'd8, 32'd12, 1'b0, 32'd8,        1'b0, 1'b0);
    step("or_8_12",   OR_,   32'd8, 32'd12, 1'b0, 32'd12,       1'b0, 1'b0);
    step("xor_8_12",  XOR_,  32'd8, 32'd12, 1'b0, 32'd4,        1'b0, 1'b0);
    step("nand_8_12", NAND_, 32'd8, 32'd12, 1'b0, 32'hFFFFFFF7, 1'b0, 1'b0);
    step("nor_8_12",  NOR_,  32'd8, 32'd12, 1'b0, 32'hFFFFFFF3, 1'b0, 1'b0);
    step("srl_8_12",  SRL,   32'd8, 32'd12, 1'b0, 32'd0,        1'b0, 1'b1);
    step("sra_8_12",  SRA,   32'd8, 32'd12, 1'b0, 32'd0,        1'b0, 1'b1);

    step("add_min_min",  ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1, 1'b1);
    step("sub_min_min",  SUB, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b0, 1'b1);
    step("mul_min_min",  MUL, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1, 1'b1);
    step("sra_min_by0",  SRA, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
    step("sltu_min_min", SLT, 32'h80000000, 32'h80000000, 1'b1, 32'h0,        1'b0, 1'b1);

    step("div_min_neg1", DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0);
    step("div_neg7_2",   DIV, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 1'b0, 1'b0);
    step("sla_ovf",      SLA, 32'h40000000, 32'd1,        1'b0, 32'h80000000, 1'b1, 1'b0);
    step("sra_neg_4",    SRA, 32'h80000000, 32'd4,        1'b0, 32'hF8000000, 1'b0, 1'b0);
    step("addu_carry",   ADD, 32'hFFFFFFFF, 32'd1,        1'b1, 32'h0,        1'b1, 1'b1);
    step("subu_borrow",  SUB, 32'd2,        32'd5,        1'b1, 32'hFFFFFFFD, 1'b1, 1'b0);
    step("mulu_ovf",     MUL, 32'h00010000, 32'h00010000, 1'b1, 32'h0,        1'b1, 1'b1);
    step("sgtu_big",     SGT, 32'hFFFFFFFF, 32'd1,        1'b1, 32'd1,        1'b0, 1'b0);
    step("nop",          NOP, 32'd7,        32'd9,        1'b0, 32'h0,        1'b0, 1'b1);

    // Operand muxes: op1 from npc, op2 from immediate.
    notBUOp = 1'b0; isImmediate = 1'b1; npc = 32'h100; immx = 32'h10;
    inp1 = 32'h5555; inp2 = 32'h3333; ALUControl = ADD; unsigned_operation = 1'b0;
    @(posedge clock); #1;
    check("mux_npc_imm", 32'h110, 1'b0, 1'b0);

    freeze = 1'b1; ALUControl = SUB;
    @(posedge clock); #1;
    check("freeze_hold", 32'h110, 1'b0, 1'b0);

    reset = 1'b1;
    @(posedge clock); #1;
    check("reset_over_freeze", 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
